// File: rtl/mdf_rs_if.sv
`default_nettype none
// ============================================================================
// Module   : mdf_rs_if
// Purpose  : Issue, CDB snoop, multiplier and result-request bundle for mdf_rs.
// Revision : 1.0
// ============================================================================
interface mdf_rs_if #(
    parameter int TAG_W = 4
);
    logic             issue_valid;
    logic             issue_ready;
    logic [TAG_W-1:0] issue_tag;
    logic [TAG_W-1:0] issue_qj;
    logic [TAG_W-1:0] issue_qk;
    logic [31:0]      issue_vj;
    logic [31:0]      issue_vk;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    logic             alu_available;
    logic             alu_en;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;

    logic             res_req;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_data;
    logic             res_ack;

    modport slave (
        input  issue_valid, issue_qj, issue_qk, issue_vj, issue_vk,
        input  cdb_valid, cdb_tag, cdb_data,
        input  alu_available, alu_result, res_ack,
        output issue_ready, issue_tag,
        output alu_en, alu_a, alu_b,
        output res_req, res_tag, res_data
    );

    modport master (
        output issue_valid, issue_qj, issue_qk, issue_vj, issue_vk,
        output cdb_valid, cdb_tag, cdb_data,
        output alu_available, alu_result, res_ack,
        input  issue_ready, issue_tag,
        input  alu_en, alu_a, alu_b,
        input  res_req, res_tag, res_data
    );
endinterface
`default_nettype wire

// File: rtl/mdf_rs.sv
`default_nettype none
// ============================================================================
// Module   : mdf_rs
// Purpose  : Multiply reservation station with CDB snooping, single in-flight
//            dispatch, fixed-latency tracking and req/ack result presentation.
// Revision : 1.0
// ============================================================================
module mdf_rs #(
    parameter int ENTRIES  = 3,
    parameter int TAG_W    = 4,
    parameter int BASE_TAG = 4,
    parameter int MUL_LAT  = 6
) (
    input  logic    clk,
    input  logic    nRST,
    mdf_rs_if.slave bus
);
    localparam int               IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int               CNT_W    = $clog2(MUL_LAT) + 1;
    localparam logic [TAG_W-1:0] BASE     = TAG_W'(BASE_TAG);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    logic [ENTRIES-1:0] busy;
    logic [ENTRIES-1:0] entry_ready;
    logic [31:0]        vj_all [ENTRIES];
    logic [31:0]        vk_all [ENTRIES];

    logic               has_free;
    logic [IDX_W-1:0]   free_idx;
    logic               has_ready;
    logic [IDX_W-1:0]   rdy_idx;

    logic               inflight;
    logic [IDX_W-1:0]   inflight_idx;
    logic [CNT_W-1:0]   cnt;

    logic               alloc;
    logic               dispatch;
    logic               req;
    logic               ack_fire;
    logic               byp_j;
    logic               byp_k;

    // Lowest-index search; iterating downward leaves the lowest match last.
    always_comb begin
        has_free  = 1'b0;
        free_idx  = '0;
        has_ready = 1'b0;
        rdy_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (entry_ready[i]) begin
                has_ready = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc    = bus.issue_valid && has_free;
    assign req      = inflight && (cnt == '0);
    assign ack_fire = req && bus.res_ack;
    assign dispatch = bus.alu_available && has_ready && !(inflight && !ack_fire);

    assign byp_j = bus.cdb_valid && (bus.issue_qj != '0) && (bus.issue_qj == bus.cdb_tag);
    assign byp_k = bus.cdb_valid && (bus.issue_qk != '0) && (bus.issue_qk == bus.cdb_tag);

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
            logic             busy_q;
            logic             disp_q;
            logic [TAG_W-1:0] qj_q;
            logic [TAG_W-1:0] qk_q;
            logic [31:0]      vj_q;
            logic [31:0]      vk_q;
            logic             snoop_j;
            logic             snoop_k;
            logic             sel_alloc;
            logic             sel_disp;
            logic             sel_free;

            assign snoop_j   = busy_q && bus.cdb_valid && (qj_q != '0) && (qj_q == bus.cdb_tag);
            assign snoop_k   = busy_q && bus.cdb_valid && (qk_q != '0) && (qk_q == bus.cdb_tag);
            assign sel_alloc = alloc && (free_idx == IDX_W'(i));
            assign sel_disp  = dispatch && (rdy_idx == IDX_W'(i));
            assign sel_free  = ack_fire && (inflight_idx == IDX_W'(i));

            assign busy[i]        = busy_q;
            assign entry_ready[i] = busy_q && !disp_q && (qj_q == '0) && (qk_q == '0);
            assign vj_all[i]      = vj_q;
            assign vk_all[i]      = vk_q;

            // A free entry is never the in-flight or ready one, so allocation
            // cannot collide with dispatch or release on the same entry.
            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    busy_q <= 1'b0;
                    disp_q <= 1'b0;
                    qj_q   <= '0;
                    qk_q   <= '0;
                    vj_q   <= '0;
                    vk_q   <= '0;
                end else if (sel_alloc) begin
                    busy_q <= 1'b1;
                    disp_q <= 1'b0;
                    qj_q   <= byp_j ? '0 : bus.issue_qj;
                    qk_q   <= byp_k ? '0 : bus.issue_qk;
                    vj_q   <= byp_j ? bus.cdb_data : bus.issue_vj;
                    vk_q   <= byp_k ? bus.cdb_data : bus.issue_vk;
                end else begin
                    if (snoop_j) begin
                        qj_q <= '0;
                        vj_q <= bus.cdb_data;
                    end
                    if (snoop_k) begin
                        qk_q <= '0;
                        vk_q <= bus.cdb_data;
                    end
                    if (sel_disp) begin
                        disp_q <= 1'b1;
                    end
                    if (sel_free) begin
                        busy_q <= 1'b0;
                        disp_q <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // A dispatch in the ack cycle hands the in-flight slot straight to the new op.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            inflight     <= 1'b0;
            inflight_idx <= '0;
            cnt          <= '0;
        end else begin
            if (dispatch) begin
                inflight     <= 1'b1;
                inflight_idx <= rdy_idx;
                cnt          <= CNT_LOAD;
            end else begin
                if (ack_fire) begin
                    inflight <= 1'b0;
                end
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign bus.issue_ready = has_free;
    assign bus.issue_tag   = BASE + TAG_W'(free_idx);

    assign bus.alu_en = dispatch;
    assign bus.alu_a  = dispatch ? vj_all[rdy_idx] : 32'd0;
    assign bus.alu_b  = dispatch ? vk_all[rdy_idx] : 32'd0;

    assign bus.res_req  = req;
    assign bus.res_tag  = req ? (BASE + TAG_W'(inflight_idx)) : '0;
    assign bus.res_data = req ? bus.alu_result : 32'd0;
endmodule
`default_nettype wire

// File: tb/tb_mdf_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdf_rs
// Purpose  : Directed self-checking bench for mdf_rs.
// Revision : 1.0
// ============================================================================
module tb_mdf_rs;
    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          en_count = 0;

    logic        auto_ack = 1'b0;
    logic        ack_d = 1'b0;
    logic        route_cdb = 1'b0;
    logic        cdb_valid_d = 1'b0;
    logic [3:0]  cdb_tag_d = '0;
    logic [31:0] cdb_data_d = '0;
    logic [31:0] mul_res = '0;

    mdf_rs_if #(.TAG_W(4)) bus ();

    mdf_rs #(.ENTRIES(3), .TAG_W(4), .BASE_TAG(4), .MUL_LAT(6)) dut (
        .clk (clk),
        .nRST(nRST),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.alu_en) en_count <= en_count + 1;

    // Non-pipelined multiplier model: product held until the next dispatch.
    always @(posedge clk) if (bus.alu_en) mul_res <= bus.alu_a * bus.alu_b;
    assign bus.alu_result = mul_res;

    assign bus.res_ack   = auto_ack ? bus.res_req : ack_d;
    assign bus.cdb_valid = route_cdb ? (bus.res_req && bus.res_ack) : cdb_valid_d;
    assign bus.cdb_tag   = route_cdb ? bus.res_tag : cdb_tag_d;
    assign bus.cdb_data  = route_cdb ? bus.res_data : cdb_data_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int lim);
        int n = 0;
        while (!bus.res_req && n < lim) begin
            tick();
            n++;
        end
        if (!bus.res_req) check("req_timeout", {31'd0, bus.res_req}, 32'd1);
    endtask

    task automatic issue(input logic [3:0] qj, input logic [31:0] vj,
                         input logic [3:0] qk, input logic [31:0] vk);
        bus.issue_valid = 1'b1;
        bus.issue_qj    = qj;
        bus.issue_vj    = vj;
        bus.issue_qk    = qk;
        bus.issue_vk    = vk;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int base;
        int stale;

        bus.issue_valid   = 1'b0;
        bus.issue_qj      = '0;
        bus.issue_qk      = '0;
        bus.issue_vj      = '0;
        bus.issue_vk      = '0;
        bus.alu_available = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_ready", {31'd0, bus.issue_ready}, 32'd1);
        check("rst_tag", {28'd0, bus.issue_tag}, 32'd4);
        check("rst_alu_en", {31'd0, bus.alu_en}, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_req", {31'd0, bus.res_req}, 32'd0);
        check("rst_res_tag", {28'd0, bus.res_tag}, 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        nRST = 1'b1;

        // 1: basic 7*6 with latency
        auto_ack = 1'b1;
        tick();
        issue(4'd0, 32'd7, 4'd0, 32'd6);
        #1;
        check("t1_issue_tag", {28'd0, bus.issue_tag}, 32'd4);
        check("t1_no_early_en", {31'd0, bus.alu_en}, 32'd0);
        tick();
        bus.issue_valid = 1'b0;
        #1;
        check("t1_alu_en", {31'd0, bus.alu_en}, 32'd1);
        check("t1_alu_a", bus.alu_a, 32'd7);
        check("t1_alu_b", bus.alu_b, 32'd6);
        t0 = cyc;
        tick();
        wait_req(20);
        check("t1_latency", cyc - t0, 32'd6);
        check("t1_res_tag", {28'd0, bus.res_tag}, 32'd4);
        check("t1_res_data", bus.res_data, 32'd42);
        tick();
        check("t1_req_drop", {31'd0, bus.res_req}, 32'd0);
        check("t1_free_tag", {28'd0, bus.issue_tag}, 32'd4);

        // 2: operand waits for CDB tag 9
        issue(4'd9, 32'd0, 4'd0, 32'd3);
        #1;
        check("t2_issue_tag", {28'd0, bus.issue_tag}, 32'd4);
        tick();
        bus.issue_valid = 1'b0;
        #1;
        check("t2_wait1", {31'd0, bus.alu_en}, 32'd0);
        tick();
        check("t2_wait2", {31'd0, bus.alu_en}, 32'd0);
        tick();
        cdb_valid_d = 1'b1;
        cdb_tag_d   = 4'd9;
        cdb_data_d  = 32'd5;
        #1;
        check("t2_wait3", {31'd0, bus.alu_en}, 32'd0);
        tick();
        cdb_valid_d = 1'b0;
        #1;
        check("t2_alu_en", {31'd0, bus.alu_en}, 32'd1);
        check("t2_alu_a", bus.alu_a, 32'd5);
        tick();
        wait_req(20);
        check("t2_res_data", bus.res_data, 32'd15);
        tick();

        // 3: same-cycle bypass on issue
        issue(4'd9, 32'd0, 4'd0, 32'd2);
        cdb_valid_d = 1'b1;
        cdb_tag_d   = 4'd9;
        cdb_data_d  = 32'd11;
        #1;
        tick();
        bus.issue_valid = 1'b0;
        cdb_valid_d     = 1'b0;
        #1;
        check("t3_alu_en", {31'd0, bus.alu_en}, 32'd1);
        check("t3_alu_a", bus.alu_a, 32'd11);
        tick();
        wait_req(20);
        check("t3_res_data", bus.res_data, 32'd22);
        tick();

        // 4: fill, stall on ack, back-to-back dispatch on ack
        auto_ack = 1'b0;
        ack_d    = 1'b0;
        base     = en_count;
        issue(4'd0, 32'd2, 4'd0, 32'd3);
        #1;
        check("t4_tag0", {28'd0, bus.issue_tag}, 32'd4);
        tick();
        issue(4'd0, 32'd4, 4'd0, 32'd5);
        #1;
        check("t4_tag1", {28'd0, bus.issue_tag}, 32'd5);
        tick();
        issue(4'd0, 32'd6, 4'd0, 32'd7);
        #1;
        check("t4_tag2", {28'd0, bus.issue_tag}, 32'd6);
        tick();
        issue(4'd0, 32'd9, 4'd0, 32'd9);
        #1;
        check("t4_full", {31'd0, bus.issue_ready}, 32'd0);
        tick();
        bus.issue_valid = 1'b0;
        wait_req(20);
        check("t4_req_tag", {28'd0, bus.res_tag}, 32'd4);
        check("t4_req_data", bus.res_data, 32'd6);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_req", {31'd0, bus.res_req}, 32'd1);
            check("t4_hold_tag", {28'd0, bus.res_tag}, 32'd4);
            check("t4_hold_data", bus.res_data, 32'd6);
            check("t4_hold_full", {31'd0, bus.issue_ready}, 32'd0);
        end
        check("t4_single_en", en_count - base, 32'd1);
        ack_d = 1'b1;
        #1;
        check("t4_b2b_en", {31'd0, bus.alu_en}, 32'd1);
        check("t4_b2b_a", bus.alu_a, 32'd4);
        check("t4_b2b_b", bus.alu_b, 32'd5);
        tick();
        ack_d = 1'b0;
        #1;
        check("t4_ready_again", {31'd0, bus.issue_ready}, 32'd1);
        check("t4_reuse_tag", {28'd0, bus.issue_tag}, 32'd4);
        check("t4_req_low", {31'd0, bus.res_req}, 32'd0);
        auto_ack = 1'b1;
        wait_req(20);
        check("t4_op1_tag", {28'd0, bus.res_tag}, 32'd5);
        check("t4_op1_data", bus.res_data, 32'd20);
        tick();
        wait_req(20);
        check("t4_op2_tag", {28'd0, bus.res_tag}, 32'd6);
        check("t4_op2_data", bus.res_data, 32'd42);
        tick();

        // 5: self-forwarding through the CDB
        route_cdb = 1'b1;
        issue(4'd0, 32'd3, 4'd0, 32'd4);
        #1;
        check("t5_tag_a", {28'd0, bus.issue_tag}, 32'd4);
        tick();
        issue(4'd4, 32'd0, 4'd0, 32'd10);
        #1;
        check("t5_tag_b", {28'd0, bus.issue_tag}, 32'd5);
        tick();
        bus.issue_valid = 1'b0;
        wait_req(20);
        check("t5_a_tag", {28'd0, bus.res_tag}, 32'd4);
        check("t5_a_data", bus.res_data, 32'd12);
        tick();
        check("t5_b_en", {31'd0, bus.alu_en}, 32'd1);
        check("t5_b_a", bus.alu_a, 32'd12);
        wait_req(20);
        check("t5_b_tag", {28'd0, bus.res_tag}, 32'd5);
        check("t5_b_data", bus.res_data, 32'd120);
        tick();
        route_cdb = 1'b0;

        // 6: reset during latency
        issue(4'd0, 32'd5, 4'd0, 32'd5);
        tick();
        bus.issue_valid = 1'b0;
        #1;
        check("t6_en", {31'd0, bus.alu_en}, 32'd1);
        tick();
        tick();
        tick();
        nRST = 1'b0;
        #1;
        check("t6_rst_req", {31'd0, bus.res_req}, 32'd0);
        check("t6_rst_en", {31'd0, bus.alu_en}, 32'd0);
        check("t6_rst_ready", {31'd0, bus.issue_ready}, 32'd1);
        check("t6_rst_tag", {28'd0, bus.issue_tag}, 32'd4);
        tick();
        nRST  = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.res_req || bus.alu_en) stale++;
        end
        check("t6_no_stale", stale, 32'd0);
        issue(4'd0, 32'd2, 4'd0, 32'd9);
        tick();
        bus.issue_valid = 1'b0;
        #1;
        check("t6_post_en", {31'd0, bus.alu_en}, 32'd1);
        tick();
        wait_req(20);
        check("t6_post_tag", {28'd0, bus.res_tag}, 32'd4);
        check("t6_post_data", bus.res_data, 32'd18);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mdf_rs.md
Name: mdf_rs

Overview:
- Reservation station and result tracker for the multiply unit, one per multiply functional unit.
- Accepts multiply instructions from the issue stage and buffers them. Captures operands by snooping the common data bus (CDB).
- Dispatches ready operations to the multiplier's state/ALU pair and tracks the fixed 6-cycle multiply latency.
- Presents the tagged product to the CDB arbiter using a req/ack handshake, where the ack is the multiplier's resultAC.

Parameters:
- ENTRIES, 3: number of reservation-station entries (2..8).
- TAG_W, 4: width of tags. Tag value 0 means "operand valid, no producer".
- BASE_TAG, 4: tag of entry 0. Entry i has tag BASE_TAG+i. Requires BASE_TAG>=1 and BASE_TAG+ENTRIES-1 < 2^TAG_W.
- MUL_LAT, 6: cycles from a sampled alu_en to the product being valid on alu_result.

Ports:
- clk  in  1  clock
- nRST  in  1  asynchronous active-low reset
- issue_valid  in  1  issue stage presents a multiply
- issue_ready  out  1  at least one free entry (registered state only)
- issue_tag  out  TAG_W  tag of the entry allocated if issue fires this cycle
- issue_qj, issue_qk  in  TAG_W  producer tags of the operands (0 = value valid)
- issue_vj, issue_vk  in  32  operand values, used when the matching q is 0
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB broadcast tag
- cdb_data  in  32  CDB broadcast value
- alu_available  in  1  multiplier can accept an operation this cycle
- alu_en  out  1  dispatch strobe; drives the multiplier's inEN
- alu_a, alu_b  out  32  multiplicand and multiplier
- alu_result  in  32  product from the multiplier
- res_req  out  1  product valid, requesting the CDB
- res_tag  out  TAG_W  tag of the product
- res_data  out  32  product value
- res_ack  in  1  CDB grant; same net as the multiplier's resultAC

Behaviour:
- Reset (async, nRST=0): all entries free, not ready, not dispatched; in-flight flag 0; latency counter 0.
  - issue_ready=1, issue_tag=BASE_TAG, alu_en=0, alu_a=alu_b=0, res_req=0, res_tag=0, res_data=0.
  - Reset mid-operation drops every buffered and in-flight op. No request survives reset.
- Entry state: busy, dispatched, qj, vj, qk, vk.
- Issue:
  - Fire = issue_valid && issue_ready.
  - Allocates the lowest-index free entry; issue_tag = BASE_TAG + that index.
  - issue_ready and issue_tag depend on registered busy bits only. An entry freed this cycle is allocatable next cycle.
  - Issue while issue_ready=0 is ignored.
- Operand capture and bypass:
  - Each clock, every busy entry with qX!=0 and qX==cdb_tag while cdb_valid=1 sets vX=cdb_data and qX=0.
  - On issue, if issue_qX!=0 matches a same-cycle valid CDB tag, the entry is written with vX=cdb_data and qX=0.
- Dispatch:
  - An entry is ready when busy, not dispatched, qj==0 and qk==0.
  - Dispatch condition: alu_available && any ready entry && !(in-flight && !res_ack).
  - alu_en is combinational. It is asserted for exactly the dispatch cycle, with alu_a/alu_b = vj/vk of the lowest-index ready entry.
  - That entry is marked dispatched and its index is latched as in-flight. The latency counter loads MUL_LAT-1.
  - Only one op is in flight at a time, matching the multiplier's non-pipelined state machine.
- Latency and result:
  - The counter decrements each cycle while nonzero.
  - When in-flight and counter==0: res_req=1, res_tag = tag of the in-flight entry, res_data=alu_result.
  - res_req stays asserted, with stable tag and data, until res_ack is sampled high.
  - On res_ack: the entry is freed (busy=0), and in-flight clears unless a dispatch occurs in the same cycle.
  - Same-cycle dispatch is legal (back-to-back: ack, then the new op's counter starts).
  - res_req first rises MUL_LAT cycles after the alu_en cycle.
- Self-forwarding: the station's own broadcast, when returned on the CDB, is captured by waiting entries like any other tag.
- Simultaneous events:
  - Issue, CDB capture, dispatch and ack may all occur in one cycle.
  - A newly issued entry cannot dispatch in its issue cycle (earliest is the next cycle).
  - A CDB tag with no matching entry is ignored.
- Full: with all ENTRIES busy, issue_ready=0 until the first res_ack. The entry is reusable the cycle after the ack.

Test Plan:
1. Reset, then issue qj=qk=0, vj=7, vk=6, with alu_available=1 and res_ack tied to res_req. Expect issue_tag=4 and alu_en one cycle later with a=7, b=6. Expect res_req 6 cycles after alu_en with res_tag=4 and res_data=42, and entry 0 free the following cycle.
2. Issue with qj=9 and vk=3. Broadcast cdb_tag=9, data=5 three cycles later. Expect no alu_en before the broadcast, dispatch the cycle after, and res_data=15.
3. Issue with qj=9 in the same cycle as a valid cdb_tag=9, data=11 (bypass), vk=2. Expect dispatch next cycle and res_data=22.
4. Fill 3 entries with ready ops and hold res_ack=0 for 10 cycles after the first res_req. Expect:
   - issue_ready=0 and a 4th issue ignored;
   - a single alu_en;
   - res_req, tag and data held stable.
   Then pulse ack: the second op dispatches in the same cycle, and issue_ready=1 the next cycle with issue_tag=4.
5. Issue A=3×4 (tag 4) and B with qj=4, vk=10 (tag 5). Route res_* back onto the CDB on ack. Expect B to capture 12 and produce res_tag=5, res_data=120.
6. Pulse nRST low while an op is 3 cycles into its latency. Expect immediate res_req=0, alu_en=0, issue_ready=1, and no stale result after release.
